// File: rtl/seg2bcd_7.sv
// seg2bcd_7: seven-segment pattern to BCD decoder with input debounce.
// Segment lines are synchronized, then a pattern must remain unchanged for
// STABLE_CYCLES consecutive samples before it is decoded and reported once.
// Results use a valid/ready handshake with a sticky overrun flag.
module seg2bcd_7 #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic       out_blank,
  output logic       out_ovf
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic {S_WAIT = 1'b0, S_LOCK = 1'b1} state_t;

  logic [6:0] seg_raw;
  logic [6:0] sync1_q, sync2_q;
  logic [6:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic       valid_q, valid_d;
  logic [3:0] digit_q, digit_d;
  logic       err_q, err_d;
  logic       blank_q, blank_d;
  logic       ovf_q, ovf_d;

  logic       emit;
  logic       xfer;
  logic [3:0] dec_digit;
  logic       dec_err;
  logic       dec_blank;

  // Segment a is the MSB so patterns read left to right as "abcdefg".
  assign seg_raw = {a, b, c, d, e, f, g};

  // Two-flop synchronizer for the asynchronous segment lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 7'd0;
      sync2_q <= 7'd0;
    end else begin
      sync1_q <= seg_raw;
      sync2_q <= sync1_q;
    end
  end

  // Decode the candidate pattern; at an emit the candidate equals s2.
  always_comb begin
    dec_digit = 4'hF;
    dec_err   = 1'b0;
    dec_blank = 1'b0;
    case (cand_q)
      7'b1111110: dec_digit = 4'd0;
      7'b0110000: dec_digit = 4'd1;
      7'b1101101: dec_digit = 4'd2;
      7'b1111001: dec_digit = 4'd3;
      7'b0110011: dec_digit = 4'd4;
      7'b1011011: dec_digit = 4'd5;
      7'b1011111: dec_digit = 4'd6;
      7'b1110000: dec_digit = 4'd7;
      7'b1111111: dec_digit = 4'd8;
      7'b1111011: dec_digit = 4'd9;
      7'b0000000: dec_blank = 1'b1;
      default:    dec_err   = 1'b1;
    endcase
  end

  // Debounce FSM next state plus the output handshake register updates.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    valid_d = valid_q;
    digit_d = digit_q;
    err_d   = err_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    emit    = 1'b0;
    xfer    = valid_q & out_ready;

    if (sync2_q != cand_q) begin
      // Any change restarts the stability count, even from the locked state.
      cand_d  = sync2_q;
      cnt_d   = 8'd1;
      state_d = S_WAIT;
    end else if (state_q == S_WAIT) begin
      if (cnt_q == CNT_LAST) begin
        emit    = 1'b1;
        state_d = S_LOCK;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (xfer) begin
      valid_d = 1'b0;
    end
    if (emit) begin
      // A result still pending without a transfer this edge is lost.
      if (valid_q && !out_ready) begin
        ovf_d = 1'b1;
      end
      valid_d = 1'b1;
      digit_d = dec_digit;
      err_d   = dec_err;
      blank_d = dec_blank;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q  <= 7'd0;
      cnt_q   <= 8'd0;
      state_q <= S_WAIT;
      valid_q <= 1'b0;
      digit_q <= 4'hF;
      err_q   <= 1'b0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      valid_q <= valid_d;
      digit_q <= digit_d;
      err_q   <= err_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_digit = digit_q;
  assign out_err   = err_q;
  assign out_blank = blank_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_seg2bcd_7.sv
// Directed testbench for seg2bcd_7 with default STABLE_CYCLES = 4.
// Outputs are sampled 1 time unit after each rising edge; inputs change then.
module tb_seg2bcd_7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0, f = 1'b0, g = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic       out_blank;
  logic       out_ovf;

  int n_pass  = 0;
  int n_total = 0;

  seg2bcd_7 #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .out_ready(out_ready), .out_valid(out_valid), .out_digit(out_digit),
    .out_err(out_err), .out_blank(out_blank), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic set_pins(input logic [6:0] p);
    {a, b, c, d, e, f, g} = p;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    set_pins(7'b0000000);
    out_ready = 1'b1;
    rst_n = 1'b0;
    step(2);
    n_total++;
    if ({out_valid, out_digit, out_err, out_blank, out_ovf} !== 8'b0_1111_000) begin
      $display("FAIL reset_values got v=%b d=%h e=%b b=%b o=%b want v=0 d=f e=0 b=0 o=0",
               out_valid, out_digit, out_err, out_blank, out_ovf);
    end else n_pass++;
    rst_n = 1'b1;
    step(3);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL blank_early got v=%b want 0 after edge 3", out_valid);
    else n_pass++;
    step(1);
    n_total++;
    if ({out_valid, out_blank, out_err, out_digit} !== 7'b1_1_0_1111) begin
      $display("FAIL blank_edge4 got v=%b b=%b e=%b d=%h want v=1 b=1 e=0 d=f",
               out_valid, out_blank, out_err, out_digit);
    end else n_pass++;
    step(1);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL blank_xfer got v=%b want 0 after edge 5", out_valid);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_digit9;
    set_pins(7'b1111011);
    step(5);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL nine_early got v=%b want 0 after edge 5", out_valid);
    else n_pass++;
    step(1);
    n_total++;
    if ({out_valid, out_digit, out_err, out_blank} !== 7'b1_1001_0_0) begin
      $display("FAIL nine_emit got v=%b d=%h e=%b b=%b want v=1 d=9 e=0 b=0",
               out_valid, out_digit, out_err, out_blank);
    end else n_pass++;
    // Held pattern must be reported only once.
    for (int i = 0; i < 8; i++) begin
      step(1);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL nine_once cycle %0d got v=%b want 0", i, out_valid);
      else n_pass++;
    end
    $display("test_digit9 done");
  endtask

  task automatic test_glitch;
    set_pins(7'b1110000);
    step(2);
    set_pins(7'b1111111);
    for (int i = 1; i <= 5; i++) begin
      step(1);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL glitch_quiet edge %0d got v=%b d=%h want v=0", i, out_valid, out_digit);
      else n_pass++;
    end
    step(1);
    n_total++;
    if ({out_valid, out_digit} !== 5'b1_1000) begin
      $display("FAIL glitch_eight got v=%b d=%h want v=1 d=8", out_valid, out_digit);
    end else n_pass++;
    step(1);
    $display("test_glitch done");
  endtask

  task automatic test_err;
    set_pins(7'b1000001);
    step(6);
    n_total++;
    if ({out_valid, out_err, out_blank, out_digit} !== 7'b1_1_0_1111) begin
      $display("FAIL err_pattern got v=%b e=%b b=%b d=%h want v=1 e=1 b=0 d=f",
               out_valid, out_err, out_blank, out_digit);
    end else n_pass++;
    step(1);
    $display("test_err done");
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    set_pins(7'b1101101);
    step(6);
    n_total++;
    if ({out_valid, out_digit} !== 5'b1_0010) $display("FAIL b2b_two got v=%b d=%h want v=1 d=2", out_valid, out_digit);
    else n_pass++;
    set_pins(7'b0110011);
    step(5);
    n_total++;
    if ({out_valid, out_digit} !== 5'b1_0010) $display("FAIL b2b_hold got v=%b d=%h want v=1 d=2", out_valid, out_digit);
    else n_pass++;
    out_ready = 1'b1;
    step(1);
    n_total++;
    if ({out_valid, out_digit, out_ovf} !== 6'b1_0100_0) begin
      $display("FAIL b2b_coincide got v=%b d=%h o=%b want v=1 d=4 o=0", out_valid, out_digit, out_ovf);
    end else n_pass++;
    step(1);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain got v=%b want 0", out_valid);
    else n_pass++;
    $display("test_back_to_back done");
  endtask

  task automatic test_ovf;
    out_ready = 1'b0;
    set_pins(7'b1111001);
    step(6);
    n_total++;
    if ({out_valid, out_digit, out_ovf} !== 6'b1_0011_0) begin
      $display("FAIL ovf_three got v=%b d=%h o=%b want v=1 d=3 o=0", out_valid, out_digit, out_ovf);
    end else n_pass++;
    set_pins(7'b1011011);
    step(6);
    n_total++;
    if ({out_valid, out_digit, out_ovf} !== 6'b1_0101_1) begin
      $display("FAIL ovf_five got v=%b d=%h o=%b want v=1 d=5 o=1", out_valid, out_digit, out_ovf);
    end else n_pass++;
    out_ready = 1'b1;
    step(1);
    n_total++;
    if ({out_valid, out_ovf} !== 2'b0_1) $display("FAIL ovf_one_xfer got v=%b o=%b want v=0 o=1", out_valid, out_ovf);
    else n_pass++;
    step(3);
    n_total++;
    if ({out_valid, out_ovf} !== 2'b0_1) $display("FAIL ovf_sticky got v=%b o=%b want v=0 o=1", out_valid, out_ovf);
    else n_pass++;
    $display("test_ovf done");
  endtask

  task automatic test_reset_mid;
    // Reset during a count.
    set_pins(7'b1110000);
    step(3);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_digit, out_err, out_blank, out_ovf} !== 8'b0_1111_000) begin
      $display("FAIL rst_mid_count got v=%b d=%h e=%b b=%b o=%b want v=0 d=f e=0 b=0 o=0",
               out_valid, out_digit, out_err, out_blank, out_ovf);
    end else n_pass++;
    step(2);
    rst_n = 1'b1;
    out_ready = 1'b0;
    step(5);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_no_spurious got v=%b want 0", out_valid);
    else n_pass++;
    step(1);
    n_total++;
    if ({out_valid, out_digit} !== 5'b1_0111) $display("FAIL rst_seven got v=%b d=%h want v=1 d=7", out_valid, out_digit);
    else n_pass++;
    // Reset with a result pending.
    set_pins(7'b0000000);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_digit, out_err, out_blank, out_ovf} !== 8'b0_1111_000) begin
      $display("FAIL rst_pending got v=%b d=%h e=%b b=%b o=%b want v=0 d=f e=0 b=0 o=0",
               out_valid, out_digit, out_err, out_blank, out_ovf);
    end else n_pass++;
    step(1);
    rst_n = 1'b1;
    step(3);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_pending_quiet got v=%b want 0", out_valid);
    else n_pass++;
    step(1);
    n_total++;
    if ({out_valid, out_blank} !== 2'b1_1) $display("FAIL rst_blank got v=%b b=%b want v=1 b=1", out_valid, out_blank);
    else n_pass++;
    $display("test_reset_mid done");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_digit9();
    test_glitch();
    test_err();
    test_back_to_back();
    test_ovf();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
